if_fetch: RTL and testbench



---
 rtl/if_fetch.sv | 171 +++++++++++++++++
 tb/tb_if_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage between the PC register and decode.
// Issues the current PC to instruction memory (req/gnt/rvalid), keeps the
// PC of every granted request in a pending queue, and collects responses
// into a small in-order {pc, instruction} buffer for decode (valid/ready).
// Requests are gated by a credit check so the buffer can never overflow.
// A taken jump empties the buffer and marks every in-flight response stale.
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight
// to the decode outputs when the buffer is empty.
module if_fetch #(
    parameter int                     BUF_DEPTH       = 2,
    parameter int                     INST_WIDTH      = 32,
    parameter int                     RV32_ADDR_WIDTH = 32,
    parameter logic                   RST_ENABLE      = 1'b0,
    parameter logic                   JUMP_ENABLE     = 1'b1,
    parameter logic [INST_WIDTH-1:0]  INST_NOP        = INST_WIDTH'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [RV32_ADDR_WIDTH-1:0] pc_addr_i,
    input  logic                       jump_en_i,
    output logic                       pc_stall_o,
    output logic                       imem_req_o,
    output logic [RV32_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]      imem_rdata_i,
    output logic                       inst_valid_o,
    output logic [INST_WIDTH-1:0]      inst_o,
    output logic [RV32_ADDR_WIDTH-1:0] inst_addr_o,
    input  logic                       id_ready_i
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] occupancy_q, occupancy_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d;
    logic [PW-1:0] buf_head_q, buf_head_d;
    logic [PW-1:0] buf_tail_q, buf_tail_d;

    logic [RV32_ADDR_WIDTH-1:0] pend_pc_q  [BUF_DEPTH];
    logic [RV32_ADDR_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];
    logic [INST_WIDTH-1:0]      buf_inst_q [BUF_DEPTH];

    logic                       flush;
    logic                       credit_ok;
    logic                       gnt_fire;
    logic                       rsp_fire;
    logic                       rsp_drop;
    logic                       rsp_keep;
    logic                       buf_valid;
    logic                       buf_pop;
    logic                       buf_wr;
    logic [RV32_ADDR_WIDTH-1:0] rsp_pc;

    assign flush = (jump_en_i == JUMP_ENABLE);

    // Credit counts both buffered entries and responses still in flight,
    // so every granted request is guaranteed a buffer slot.
    assign credit_ok   = ({1'b0, outstanding_q} + {1'b0, occupancy_q}) < DEPTH_C;
    assign imem_req_o  = credit_ok & ~flush;
    assign imem_addr_o = pc_addr_i;
    assign gnt_fire    = imem_req_o & imem_gnt_i;
    assign pc_stall_o  = ~flush & ~gnt_fire;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire  = imem_rvalid_i & (outstanding_q != '0);
    assign rsp_drop  = rsp_fire & ((discard_q != '0) | flush);
    assign rsp_keep  = rsp_fire & ~rsp_drop;
    assign rsp_pc    = pend_pc_q[pend_rd_q];

    assign buf_valid = (occupancy_q != '0);
    assign buf_pop   = buf_valid & id_ready_i;

`ifdef FETCH_BYPASS_EN
    logic byp_hit;

    // Forward a live response when there is nothing older to present.
    assign byp_hit = rsp_keep & ~buf_valid;
    assign buf_wr  = rsp_keep & ~(byp_hit & id_ready_i);

    // Head selection: buffered entry first, otherwise the bypassed response.
    always_comb begin
        inst_valid_o = buf_valid | byp_hit;
        inst_o       = INST_NOP;
        inst_addr_o  = '0;
        if (buf_valid) begin
            inst_o      = buf_inst_q[buf_head_q];
            inst_addr_o = buf_pc_q[buf_head_q];
        end else if (byp_hit) begin
            inst_o      = imem_rdata_i;
            inst_addr_o = rsp_pc;
        end
    end
`else
    assign buf_wr = rsp_keep;

    // Head outputs come only from registered buffer state.
    always_comb begin
        inst_valid_o = buf_valid;
        inst_o       = INST_NOP;
        inst_addr_o  = '0;
        if (buf_valid) begin
            inst_o      = buf_inst_q[buf_head_q];
            inst_addr_o = buf_pc_q[buf_head_q];
        end
    end
`endif

    // Next-state for counters and queue pointers, including flush handling.
    always_comb begin
        outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
        pend_wr_d     = pend_wr_q + PW'(gnt_fire);
        pend_rd_d     = pend_rd_q + PW'(rsp_fire);
        occupancy_d   = occupancy_q;
        discard_d     = discard_q;
        buf_head_d    = buf_head_q;
        buf_tail_d    = buf_tail_q;
        if (flush) begin
            // Every response still in flight after this cycle is stale,
            // including ones already marked; count each exactly once.
            occupancy_d = '0;
            buf_head_d  = buf_tail_q;
            discard_d   = outstanding_q - CW'(rsp_fire);
        end else begin
            occupancy_d = occupancy_q + CW'(buf_wr) - CW'(buf_pop);
            buf_head_d  = buf_head_q + PW'(buf_pop);
            buf_tail_d  = buf_tail_q + PW'(buf_wr);
            discard_d   = discard_q - CW'(rsp_drop);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            outstanding_q <= '0;
            occupancy_q   <= '0;
            discard_q     <= '0;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            buf_head_q    <= '0;
            buf_tail_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            occupancy_q   <= occupancy_d;
            discard_q     <= discard_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            buf_head_q    <= buf_head_d;
            buf_tail_q    <= buf_tail_d;
        end
    end

    // Storage arrays; contents are only meaningful under the pointers/counts,
    // so they need no reset.
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            pend_pc_q[pend_wr_q] <= pc_addr_i;
        end
        if (buf_wr) begin
            buf_pc_q[buf_tail_q]   <= rsp_pc;
            buf_inst_q[buf_tail_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: models the PC register and a simple in-order
// instruction memory, and keeps a scoreboard of the next PC decode must see.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr_i;
    logic        jump_en_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        id_ready_i;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr_i     (pc_addr_i),
        .jump_en_i     (jump_en_i),
        .pc_stall_o    (pc_stall_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .id_ready_i    (id_ready_i)
    );

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
    localparam logic [31:0] T1_NEXT = 32'h2C;
`else
    localparam int LAT = 2;
    localparam logic [31:0] T1_NEXT = 32'h1C;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ngrant = 0;
    int          first_gnt = -1;
    int          first_val = -1;
    int          g0;
    logic        rsp_en;
    logic        ok;
    logic [31:0] exp_addr;
    logic [31:0] jump_tgt;
    logic [31:0] held;
    logic [31:0] mq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] code_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One clock: sample before the edge, then advance the PC register and
    // memory models and drive the next cycle's response.
    task automatic tick();
        logic        s_fire, s_rv, s_stall, s_jump;
        logic [31:0] s_addr;
        @(negedge clk);
        s_fire  = imem_req_o & imem_gnt_i;
        s_addr  = imem_addr_o;
        s_rv    = imem_rvalid_i;
        s_stall = pc_stall_o;
        s_jump  = jump_en_i;
        if (inst_valid_o && id_ready_i) begin
            if (first_val < 0) first_val = cyc;
            check("seq_addr", inst_addr_o, exp_addr);
            check("seq_inst", inst_o, code_of(exp_addr));
            exp_addr = exp_addr + 32'd4;
        end
        if (s_jump) exp_addr = jump_tgt;
        if (s_fire) begin
            ngrant++;
            if (first_gnt < 0) first_gnt = cyc;
        end
        @(posedge clk);
        #1;
        if (s_rv && mq.size() > 0) void'(mq.pop_front());
        if (s_fire) mq.push_back(s_addr);
        if (s_jump) pc_addr_i = jump_tgt;
        else if (!s_stall) pc_addr_i = pc_addr_i + 32'd4;
        if (rsp_en && mq.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = code_of(mq[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", inst_valid_o, 1'b0);
        check("arst_inst", inst_o, 32'h13);
        check("arst_addr", inst_addr_o, 32'h0);
        mq.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        pc_addr_i     = 32'h0;
        jump_en_i     = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_addr = 32'h0;
        #1;
        check("arst_req", imem_req_o, 1'b1);
        check("arst_iaddr", imem_addr_o, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; jump_en_i = 1'b0; jump_tgt = '0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b1;
        pc_addr_i = 32'h0; rsp_en = 1'b1; exp_addr = 32'h0;
        #1;
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, 32'h13);
        check("rst_addr", inst_addr_o, 32'h0);
        check("rst_req", imem_req_o, 1'b1);
        check("rst_stall", pc_stall_o, 1'b1);
        check("rst_iaddr", imem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_gnt_i = 1'b1;
        #1;
        check("t1_stall_c0", pc_stall_o, 1'b0);

        // T1: streaming from reset
        repeat (12) tick();
        check("t1_first_gnt", first_gnt, 0);
        check("t1_latency", first_val - first_gnt, LAT);
        check("t1_progress", exp_addr, T1_NEXT);

        // T2: grant withheld for 3 cycles
        imem_gnt_i = 1'b0;
        held = pc_addr_i;
        repeat (3) begin
            #1;
            check("t2_stall", pc_stall_o, 1'b1);
            check("t2_addr", imem_addr_o, held);
            tick();
        end
        imem_gnt_i = 1'b1;
        repeat (6) tick();
        imem_gnt_i = 1'b0;
        repeat (4) tick();
        #1;
        check("t2_drained", inst_valid_o, 1'b0);
        check("t2_pc_sync", pc_addr_i, exp_addr);

        // T3: decode stalls for 5 cycles
        id_ready_i = 1'b0;
        imem_gnt_i = 1'b1;
        g0 = ngrant;
        repeat (5) begin
            #1;
            if (inst_valid_o) begin
                check("t3_head_addr", inst_addr_o, exp_addr);
                check("t3_head_inst", inst_o, code_of(exp_addr));
            end
            tick();
        end
        check("t3_grants", ngrant - g0, 2);
        #1;
        check("t3_req", imem_req_o, 1'b0);
        check("t3_valid", inst_valid_o, 1'b1);
        id_ready_i = 1'b1;
        repeat (8) tick();

        // T6: asynchronous reset with two entries buffered
        id_ready_i = 1'b0;
        repeat (5) tick();
        #1;
        check("t6_pre_valid", inst_valid_o, 1'b1);
        check("t6_pre_occ", 32'(dut.occupancy_q), 2);
        apply_reset();
        id_ready_i = 1'b1;
        imem_gnt_i = 1'b1;
        rsp_en     = 1'b1;

        // T4: jump with two stale requests at 0x8 / 0xC
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pc_addr_i == 32'h8) begin ok = 1'b1; break; end
        end
        check("t4_wait_pc8", ok, 1'b1);
        rsp_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mq.size() == 2 && !inst_valid_o) begin ok = 1'b1; break; end
            tick();
        end
        check("t4_wait_out2", ok, 1'b1);
        check("t4_q0", mq[0], 32'h8);
        check("t4_q1", mq[1], 32'hC);
        jump_en_i = 1'b1;
        jump_tgt  = 32'h100;
        rsp_en    = 1'b1;
        #1;
        check("t4_jump_req", imem_req_o, 1'b0);
        check("t4_jump_stall", pc_stall_o, 1'b0);
        tick();
        jump_en_i = 1'b0;
        repeat (2) begin
            #1;
            check("t4_dropped", inst_valid_o, 1'b0);
            tick();
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exp_addr == 32'h104) begin ok = 1'b1; break; end
        end
        check("t4_target_seen", ok, 1'b1);
        check("t4_discard", 32'(dut.discard_q), 0);

        // T5: jump together with rvalid and a decode handshake
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (inst_valid_o && imem_rvalid_i) begin ok = 1'b1; break; end
            tick();
        end
        check("t5_wait", ok, 1'b1);
        jump_en_i = 1'b1;
        jump_tgt  = 32'h200;
        tick();
        jump_en_i = 1'b0;
        #1;
        check("t5_empty", inst_valid_o, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (exp_addr == 32'h204) begin ok = 1'b1; break; end
        end
        check("t5_target_seen", ok, 1'b1);
        check("t5_discard", 32'(dut.discard_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
